// File: rtl/rx_frame_ctrl.sv
// UART receive frame controller: start detect, mid-bit sampling via bsc bitProgress, stop/parity check.
// Optional RX_PARITY_EN macro adds an even-parity bit between the data bits and the stop bit.
module rx_frame_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int MID_SAMPLE  = 7,
  parameter int LAST_SAMPLE = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 serial_in_i,
  input  logic [3:0]           bit_progress_i,
  output logic                 enable_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 char_received_o,
  output logic                 frame_err_o
);

  localparam logic [3:0] MID      = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST     = 4'(LAST_SAMPLE);
  localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] shreg_d;
  logic [3:0]           idx_q;
  logic                 enable_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 char_q;
  logic                 err_q;
  logic                 at_mid;
  logic                 at_last;
  logic                 stop_good;

  assign at_mid  = (bit_progress_i == MID);
  assign at_last = (bit_progress_i == LAST);

  // Right shift: the first (LSB) bit received ends up in bit 0 after DATA_BITS shifts.
  always_comb begin
    shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
  end

`ifdef RX_PARITY_EN
  logic par_err_q;
  assign stop_good = rx_s_q && !par_err_q;
`else
  assign stop_good = rx_s_q;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      shreg_q   <= '0;
      idx_q     <= '0;
      enable_q  <= 1'b0;
      data_q    <= '0;
      char_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= serial_in_i;
      rx_s_q    <= rx_meta_q;
      char_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Level-based start detect: a held-low line re-arms after every STOP.
          if (!rx_s_q) begin
            state_q  <= S_START;
            enable_q <= 1'b1;
`ifdef RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (at_mid && rx_s_q) begin
            state_q  <= S_IDLE;
            enable_q <= 1'b0;
          end else if (at_last) begin
            state_q <= S_DATA;
            idx_q   <= '0;
          end
        end
        S_DATA: begin
          if (at_mid) begin
            shreg_q <= shreg_d;
          end
          if (at_last) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == LAST_IDX) begin
`ifdef RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef RX_PARITY_EN
        S_PARITY: begin
          if (at_mid) begin
            par_err_q <= (rx_s_q != (^shreg_q));
          end
          if (at_last) begin
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Leave at mid-stop so a back-to-back start bit is seen with half a bit of margin.
          if (at_mid) begin
            state_q  <= S_IDLE;
            enable_q <= 1'b0;
            if (stop_good) begin
              data_q <= shreg_q;
              char_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign enable_o        = enable_q;
  assign data_o          = data_q;
  assign char_received_o = char_q;
  assign frame_err_o     = err_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: bsc model, table-driven frames, corner sequences, random frames vs. reference.
module tb_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial_in = 1'b1;
  logic [3:0] bit_progress;
  logic       enable;
  logic [7:0] data;
  logic       char_received;
  logic       frame_err;

  rx_frame_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .serial_in_i    (serial_in),
    .bit_progress_i (bit_progress),
    .enable_o       (enable),
    .data_o         (data),
    .char_received_o(char_received),
    .frame_err_o    (frame_err)
  );

  always #5 clk = ~clk;

  // bsc: counts 0..15 while enable is high, held at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_progress <= 4'd0;
    else if (!enable) bit_progress <= 4'd0;
    else bit_progress <= bit_progress + 4'd1;
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_char = 0;
  int n_err = 0;
  int viol = 0;
  int char_cyc[$];
  logic prev_strobe = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (char_received) begin
      n_char++;
      char_cyc.push_back(cyc);
    end
    if (frame_err) n_err++;
    if (char_received && frame_err) viol++;
    if ((char_received || frame_err) && prev_strobe) viol++;
    prev_strobe = char_received || frame_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    serial_in = v;
    repeat (16) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef RX_PARITY_EN
    bit_out(par);
`else
    if (par === 1'bx) serial_in = 1'b1;
`endif
    bit_out(stop);
    serial_in = 1'b1;
  endtask

  task automatic idle_gap(input int n);
    serial_in = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       par_ok;
    logic       stop;
    int         exp_char;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] model_data;

  initial begin
    int c0, e0, last_bp, rose, fell;
    logic [7:0] b, d0;
    logic stop, par_ok, par;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_enable", enable, 0);
    check("reset_data", data, 0);
    check("reset_char", char_received, 0);
    check("reset_err", frame_err, 0);
    rst_n = 1'b1;
    idle_gap(5);

    vecs.push_back('{8'h55, 1'b1, 1'b1, 1, 0, 8'h55});
    vecs.push_back('{8'h3C, 1'b1, 1'b0, 0, 1, 8'h55});
    vecs.push_back('{8'h81, 1'b1, 1'b1, 1, 0, 8'h81});
    vecs.push_back('{8'h00, 1'b1, 1'b1, 1, 0, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b1, 1, 0, 8'hFF});
`ifdef RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 1, 0, 8'h07});
    vecs.push_back('{8'h5A, 1'b0, 1'b1, 0, 1, 8'h07});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      c0 = n_char;
      e0 = n_err;
      par = vecs[i].par_ok ? ^vecs[i].b : ~^vecs[i].b;
      send_frame(vecs[i].b, par, vecs[i].stop);
      idle_gap(24);
      check($sformatf("vec%0d_char", i), n_char - c0, vecs[i].exp_char);
      check($sformatf("vec%0d_err", i), n_err - e0, vecs[i].exp_err);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end

    // back-to-back frames, no idle gap
    c0 = n_char;
    send_frame(8'hA3, ^8'hA3, 1'b1);
    check("b2b_first_data", data, 8'hA3);
    send_frame(8'h0F, ^8'h0F, 1'b1);
    idle_gap(24);
    check("b2b_count", n_char - c0, 2);
    check("b2b_data", data, 8'h0F);
`ifdef RX_PARITY_EN
    check("b2b_spacing", char_cyc[$] - char_cyc[$-1], 16 * 11);
`else
    check("b2b_spacing", char_cyc[$] - char_cyc[$-1], 16 * 10);
`endif

    // glitch: 4 clk low in idle
    c0 = n_char;
    e0 = n_err;
    d0 = data;
    serial_in = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    serial_in = 1'b1;
    rose = 0;
    for (int i = 0; i < 10 && rose == 0; i++) begin
      @(negedge clk);
      if (enable) rose = 1;
    end
    check("glitch_enable_rose", rose, 1);
    fell = 0;
    last_bp = -1;
    for (int i = 0; i < 30 && fell == 0; i++) begin
      @(negedge clk);
      if (enable) last_bp = bit_progress;
      else fell = 1;
    end
    check("glitch_enable_fell", fell, 1);
    check("glitch_drop_bp", last_bp, 7);
    idle_gap(10);
    check("glitch_no_strobe", (n_char - c0) + (n_err - e0), 0);
    check("glitch_data", data, d0);

    // reset in the middle of data bit 4 of 0xFF
    c0 = n_char;
    e0 = n_err;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    serial_in = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_enable", enable, 0);
    check("rst_mid_data", data, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_gap(200);
    check("rst_mid_no_strobe", (n_char - c0) + (n_err - e0), 0);
    send_frame(8'h12, ^8'h12, 1'b1);
    idle_gap(24);
    check("rst_then_data", data, 8'h12);

    // random frames against reference model
    model_data = data;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
`ifdef RX_PARITY_EN
      par_ok = ($urandom_range(0, 3) != 0);
`else
      par_ok = 1'b1;
`endif
      par = par_ok ? ^b : ~^b;
      c0 = n_char;
      e0 = n_err;
      send_frame(b, par, stop);
      idle_gap(24);
      if (stop && par_ok) model_data = b;
      check($sformatf("rnd%0d_char", i), n_char - c0, (stop && par_ok) ? 1 : 0);
      check($sformatf("rnd%0d_err", i), n_err - e0, (stop && par_ok) ? 0 : 1);
      check($sformatf("rnd%0d_data", i), data, model_data);
    end

    check("strobe_exclusive_single_cycle", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
